// File: rtl/reg_wr_arbiter.sv
// rtl/reg_wr_arbiter.sv - round-robin arbiter sharing one register-bank write port
//
// Purpose: NREQ requesters (writeback, load, CSR, debug, ...) compete for a
// single bank write port. One requester is granted per cycle in round-robin
// order, and the accepted write is registered onto wen/waddr/wdata.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   req_valid  per-requester write request
//   req_addr   packed addresses, requester i at [i*AW +: AW]
//   req_data   packed data, requester i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot grant (combinational)
//   stall      bank busy; nothing is granted while high
//   wen        registered bank write enable
//   waddr      registered bank write address
//   wdata      registered bank write data
//   grant_id   registered index of the requester behind the current wen cycle

module reg_wr_arbiter #(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 64,
  parameter int AW           = 5,
  parameter int ZERO_DISCARD = 1,
  localparam int IW          = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  stall,
  output logic                  wen,
  output logic [AW-1:0]         waddr,
  output logic [WIDTH-1:0]      wdata,
  output logic [IW-1:0]         grant_id
);

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win;
  logic [IW-1:0]    idx;
  logic             found;
  logic             hs;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;

  // Scan ptr, ptr+1, ... with natural IW-bit wraparound (NREQ is a power
  // of two), keeping the first valid requester encountered.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IW'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign hs        = found && !stall && !rst;
  assign req_ready = hs ? (NREQ'(1) << win) : '0;
  assign win_addr  = req_addr[int'(win)*AW +: AW];
  assign win_data  = req_data[int'(win)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wen      <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      grant_id <= '0;
      ptr      <= '0;
    end else if (hs) begin
      // Address-0 writes are still accepted and still rotate the pointer;
      // only the bank strobe is suppressed.
      wen      <= !((ZERO_DISCARD != 0) && (win_addr == '0));
      waddr    <= win_addr;
      wdata    <= win_data;
      grant_id <= win;
      ptr      <= win + IW'(1);
    end else begin
      wen <= 1'b0;
    end
  end

endmodule
